ps2_frame_rx: RTL and testbench
===============================

# ps2_frame_rx

PS/2 keyboard link receiver that sits directly upstream of the scan-code decoder. It synchronises the raw `ps2_clk`/`ps2_data` pins and deserialises 11-bit frames (start, 8 data bits LSB-first, odd parity, stop). Each good byte is buffered in a small FIFO. Bytes are presented downstream as a one-cycle `ready` pulse with `data_out`, which matches the decoder's `ready`/`data_in` input.

## Interface
- `FIFO_DEPTH`, default 8: buffered bytes; must be a power of 2, at least 2.
- `TIMEOUT_CYCLES`, default 50000: number of clk cycles without a ps2_clk falling edge, while mid-frame, before the frame is aborted.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to clk.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to clk.
- `hold`  in  1  consumer stall; while it is 1, no byte is popped.
- `ready`  out  1  one-cycle strobe: `data_out` holds a new byte.
- `data_out`  out  8  last popped byte; holds its value between strobes.
- `frame_err`  out  1  one-cycle pulse on a bad parity, a bad stop bit, or a timeout.
- `overflow`  out  1  sticky; set when a good byte is dropped because the FIFO is full. Cleared only by `rst`.

## Operation
- **Reset values.** `ready`, `data_out`, `frame_err` and `overflow` are all 0. The synchroniser registers reset to 1. The state machine resets to IDLE. The FIFO pointers, bit counter and timeout counter reset to 0.
- **Synchroniser.** Each pin passes through 2 flops; `ps2_clk` has a third flop, c2.
- **Falling edge.** `fall = c2 & ~c1`. The data sample is the synchronised `ps2_data` in the same cycle.
- **State machine (IDLE, RECV).**
  - IDLE: on `fall` with sample 0 (start bit), go to RECV with bitcnt = 1. A `fall` with sample 1 is ignored.
  - RECV: on each `fall`, act on bitcnt:
    - 1–8: shift the sample into `shreg[bitcnt-1]`, so LSB arrives first.
    - 9: latch the parity bit.
    - 10: check the stop bit, then return to IDLE.
  - Frame good when `^shreg ^ parity == 1` and stop == 1.
    - Good frame, FIFO not full: push `shreg`.
    - Good frame, FIFO full: drop the byte and set `overflow`.
    - Bad frame: pulse `frame_err` and push nothing.
- **Timeout.**
  - In RECV the counter increments each cycle and clears on each `fall`.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_err`, go to IDLE, clear bitcnt and the counter.
  - In IDLE the counter is held at 0.
- **FIFO.**
  - Read/write pointers are log2(DEPTH)+1 bits wide.
  - Empty when the pointers are equal; full when the MSBs differ and the rest are equal.
  - Full/empty are evaluated from pre-edge state. A push into a full FIFO is dropped even if a pop happens in the same cycle.
  - A push into an empty FIFO is not visible to the pop logic until the next cycle.
- **Output stage.**
  - Each cycle, if the FIFO is non-empty and `hold == 0`: `ready <= 1`, `data_out <= mem[rd]`, rd++.
  - Otherwise `ready <= 0`.
  - Back-to-back pops are allowed, so `ready` may be high on consecutive cycles with distinct bytes.
  - Bytes leave in arrival order.
- **Reset mid-frame.** A partial frame is discarded and the FIFO is emptied. The next start bit seen after reset deasserts starts a fresh frame.

## Timing
- Let edge E be the clk edge at which a pin's falling `ps2_clk` is first captured in the first synchroniser flop. `fall` is high for exactly 1 cycle, after edge E+1.
- For the stop bit:
  - The push occurs at edge E+2.
  - With the FIFO previously empty and `hold = 0`, `ready` rises at edge E+3 and lasts 1 cycle.
- `frame_err` rises 1 cycle after the push edge would have occurred (or 1 cycle after timeout expiry) and lasts 1 cycle.
- `hold` is sampled at the same edge that would register `ready`. Asserting `hold` suppresses the next pop with no extra delay.
- `ps2_clk` low/high phases are at least 3 clk cycles each; shorter pulses are unsupported.

## Test plan
1. Frame for 0x1C: start 0, data 0,0,1,1,1,0,0,0 (LSB first), parity 0, stop 1 → exactly one `ready` pulse with `data_out = 0x1C`; `frame_err = 0`; `ready` at E+3 of the stop-bit fall.
2. Frames 0xF0 (parity 1) then 0x1C, `hold = 0` → two separate `ready` pulses, carrying 0xF0 then 0x1C.
3. 0x1C sent with parity 1 → one `frame_err` pulse, no `ready`, `overflow = 0`. A following good 0x1C frame is received normally.
4. `hold = 1`, send the 9 bytes 0x01–0x09 (DEPTH 8) → `overflow = 1` after the 9th frame. Release `hold` → 8 consecutive `ready` pulses carrying 0x01–0x08; 0x09 is lost; `overflow` stays 1.
5. `TIMEOUT_CYCLES = 100`: send start bit plus 3 data bits, then stop clocking → `frame_err` pulse about 100 cycles after the last `fall`, no `ready`. A following 0x2A frame yields `ready` with 0x2A.
6. Assert `rst` at bit 5 of a frame while the FIFO holds 2 bytes → all outputs 0 immediately, no `ready` after release. A following 0x55 frame yields a single `ready` with 0x55.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises ps2_clk/ps2_data, deserialises 11-bit odd-parity frames
// and buffers good bytes; a byte is pushed 2 clk after the stop-bit fall is captured, and popped when hold is low.
module ps2_frame_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       hold,
  output logic       ready,
  output logic [7:0] data_out,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [TW-1:0] TCNT_ONE = 1;
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES);

  logic c0, c1, c2;
  logic d0, d1;
  logic fall;
  logic sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0 <= 1'b1;
      c1 <= 1'b1;
      c2 <= 1'b1;
      d0 <= 1'b1;
      d1 <= 1'b1;
    end else begin
      c0 <= ps2_clk;
      c1 <= c0;
      c2 <= c1;
      d0 <= ps2_data;
      d1 <= d0;
    end
  end

  assign fall   = c2 & ~c1;
  assign sample = d1;

  logic [0:0]    state;
  logic [3:0]    bitcnt;
  logic [7:0]    shreg;
  logic          parity;
  logic [TW-1:0] tcnt;
  logic          err_req;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          fifo_empty;
  logic          fifo_full;

  logic          stop_fall;
  logic          frame_good;
  logic          push;
  logic          drop;
  logic          stop_bad;
  logic          tmo;
  logic          pop;
  logic [2:0]    sh_idx;

  assign sh_idx     = 3'(bitcnt - 4'd1);
  assign stop_fall  = (state == RECV) && fall && (bitcnt == 4'd10);
  assign frame_good = (^shreg ^ parity) & sample;
  assign push       = stop_fall && frame_good && !fifo_full;
  assign drop       = stop_fall && frame_good && fifo_full;
  assign stop_bad   = stop_fall && !frame_good;
  assign tmo        = (state == RECV) && !fall && (tcnt == TCNT_MAX);

  // Flags come from registered pointers, so a same-cycle push/pop never sees the other's effect.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && !hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= 4'd0;
      shreg     <= 8'd0;
      parity    <= 1'b0;
      tcnt      <= '0;
      err_req   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      err_req   <= stop_bad | tmo;
      frame_err <= err_req;
      case (state)
        IDLE: begin
          tcnt   <= '0;
          bitcnt <= 4'd0;
          if (fall && !sample) begin
            state  <= RECV;
            bitcnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            tcnt <= '0;
            if (bitcnt <= 4'd8) begin
              shreg[sh_idx] <= sample;
            end else if (bitcnt == 4'd9) begin
              parity <= sample;
            end
            if (bitcnt == 4'd10) begin
              state  <= IDLE;
              bitcnt <= 4'd0;
            end else begin
              bitcnt <= bitcnt + 4'd1;
            end
          end else if (tmo) begin
            state  <= IDLE;
            bitcnt <= 4'd0;
            tcnt   <= '0;
          end else begin
            tcnt <= tcnt + TCNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready    <= 1'b0;
      data_out <= 8'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= mem[rd_ptr[AW-1:0]];
      end
      ready <= pop;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomised and directed bench for ps2_frame_rx against a cycle-level queue model of the receiver.
module tb_ps2_frame_rx;

  localparam int DEPTH = 8;
  localparam int T     = 100;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       hold     = 1'b0;
  logic       ready;
  logic [7:0] data_out;
  logic       frame_err;
  logic       overflow;

  ps2_frame_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .hold(hold),
    .ready(ready), .data_out(data_out), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state: bytes sitting in the FIFO, plus the expected outputs after each edge.
  logic [7:0] q[$];
  logic       e_ready = 1'b0;
  logic [7:0] e_data = 8'd0;
  logic       e_err = 1'b0;
  logic       e_ovf = 1'b0;
  logic       err_pend = 1'b0;
  bit         m_full;
  bit         ev_valid = 0;
  bit         ev_good = 0;
  int         ev_cyc = 0;
  logic [7:0] ev_val = 8'd0;

  int tmo_lo = -1000;
  int tmo_hi = -1000;
  int tmo_seen = 0;
  logic [7:0] got_b[$];
  int         got_c[$];
  int  err_cnt = 0;
  bit  chk_en = 0;
  bit  rand_hold = 0;

  int n, b0, e0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Stop-bit fall driven after edge n is captured at n+1, pushed at n+3, popped at n+4 at the earliest.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      e_ready  = 1'b0;
      e_data   = 8'd0;
      e_err    = 1'b0;
      e_ovf    = 1'b0;
      err_pend = 1'b0;
      ev_valid = 0;
    end else begin
      cyc    = cyc + 1;
      m_full = (q.size() == DEPTH);
      if (q.size() != 0 && !hold) begin
        e_ready = 1'b1;
        e_data  = q.pop_front();
      end else begin
        e_ready = 1'b0;
      end
      e_err    = err_pend;
      err_pend = 1'b0;
      if (ev_valid && ev_cyc == cyc) begin
        ev_valid = 0;
        if (!ev_good) err_pend = 1'b1;
        else if (m_full) e_ovf = 1'b1;
        else q.push_back(ev_val);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(e_ready));
      chk("data_out", 32'(data_out), 32'(e_data));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      if (cyc >= tmo_lo && cyc <= tmo_hi) begin
        if (frame_err === 1'b1) tmo_seen++;
      end else begin
        chk("frame_err", 32'(frame_err), 32'(e_err));
      end
      if (ready === 1'b1) begin
        got_b.push_back(data_out);
        got_c.push_back(cyc);
      end
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_hold) begin
      #1;
      hold = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                      input int nbits, output int last_n);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    last_n = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cycles($urandom_range(3, 10));
      ps2_clk = 1'b0;
      last_n  = cyc;
      if (i == 10) begin
        ev_cyc   = cyc + 3;
        ev_good  = !bad_par && !bad_stop;
        ev_val   = d;
        ev_valid = 1;
      end
      cycles($urandom_range(3, 10));
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    int ln;
    send(d, bad_par, bad_stop, 11, ln);
    cycles(8);
  endtask

  function automatic logic [31:0] got_at(input int idx);
    if (idx < got_b.size()) return 32'(got_b[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #1 rst = 1'b1;
    cycles(3);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    rst = 1'b0;
    chk_en = 1;
    cycles(5);

    // Single 0x1C frame, ready lands 4 edges after the stop-bit fall is driven.
    b0 = got_b.size();
    send(8'h1C, 0, 0, 11, n);
    cycles(8);
    chk("t1_count", 32'(got_b.size() - b0), 32'd1);
    chk("t1_data", got_at(b0), 32'h1C);
    chk("t1_latency", (got_c.size() > b0) ? 32'(got_c[b0]) : 32'hFFFF_FFFF, 32'(n + 4));

    b0 = got_b.size();
    frame(8'hF0, 0, 0);
    frame(8'h1C, 0, 0);
    chk("t2_count", 32'(got_b.size() - b0), 32'd2);
    chk("t2_first", got_at(b0), 32'hF0);
    chk("t2_second", got_at(b0 + 1), 32'h1C);

    b0 = got_b.size();
    e0 = err_cnt;
    frame(8'h1C, 1, 0);
    chk("t3_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("t3_no_ready", 32'(got_b.size() - b0), 32'd0);
    chk("t3_overflow", 32'(overflow), 32'h0);
    frame(8'h1C, 0, 0);
    chk("t3_recover", got_at(b0), 32'h1C);

    rand_hold = 1;
    for (int i = 0; i < 40; i++) begin
      frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      cycles($urandom_range(2, 15));
    end
    rand_hold = 0;
    cycles(1);
    hold = 1'b0;
    cycles(20);

    // Nine bytes into a stalled 8-deep FIFO: the ninth is dropped.
    hold = 1'b1;
    b0 = got_b.size();
    for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0);
    cycles(3);
    chk("t4_overflow_set", 32'(overflow), 32'h1);
    chk("t4_held", 32'(got_b.size() - b0), 32'd0);
    hold = 1'b0;
    cycles(15);
    chk("t4_count", 32'(got_b.size() - b0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t4_byte", got_at(b0 + i), 32'(i + 1));
      if (got_c.size() > b0 + i)
        chk("t4_back_to_back", 32'(got_c[b0 + i] - got_c[b0]), 32'(i));
    end
    chk("t4_overflow_sticky", 32'(overflow), 32'h1);

    // Start bit plus three data bits, then silence.
    b0 = got_b.size();
    send(8'hA5, 0, 0, 4, n);
    tmo_seen = 0;
    tmo_lo = n + T - 5;
    tmo_hi = n + T + 10;
    cycles(T + 15);
    chk("t5_timeout_pulse", 32'(tmo_seen), 32'd1);
    chk("t5_no_ready", 32'(got_b.size() - b0), 32'd0);
    frame(8'h2A, 0, 0);
    chk("t5_recover", got_at(b0), 32'h2A);

    hold = 1'b1;
    frame(8'h11, 0, 0);
    frame(8'h22, 0, 0);
    send(8'h77, 0, 0, 6, n);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(ready), 32'h0);
    chk("t6_rst_data_out", 32'(data_out), 32'h0);
    chk("t6_rst_frame_err", 32'(frame_err), 32'h0);
    chk("t6_rst_overflow", 32'(overflow), 32'h0);
    cycles(2);
    rst = 1'b0;
    hold = 1'b0;
    b0 = got_b.size();
    cycles(20);
    chk("t6_fifo_emptied", 32'(got_b.size() - b0), 32'd0);
    frame(8'h55, 0, 0);
    chk("t6_count", 32'(got_b.size() - b0), 32'd1);
    chk("t6_data", got_at(b0), 32'h55);
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

endmodule
